// File: rtl/robo_pkg.sv
// Shared definitions for the robot supervisor: the state set, default
// timing constants, and the mapping from each state to its status outputs.
package robo_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_ROBO = 3'd1,
        S_RUN      = 3'd2,
        S_TURN     = 3'd3,
        S_COLLECT  = 3'd4,
        S_HALT     = 3'd5,
        S_FAULT    = 3'd6
    } robo_state_t;

    // Default parameter values for robo_supervisor.
    localparam int DEF_TURN_CYCLES  = 8;
    localparam int DEF_CLAW_CYCLES  = 4;
    localparam int DEF_STUCK_LIMIT  = 4;
    localparam int DEF_HALT_CYCLES  = 4;

    // The robot FSM is held in reset this many cycles on every (re)start.
    localparam int RST_ROBO_CYCLES  = 2;

    // Width of the shared phase timer and of the streak/idle counters.
    localparam int TIMER_W = 16;
    localparam int CNT_W   = 8;

    // Per-state output flags; motor_fwd is not here because it depends
    // on the command sampled in RUN rather than on the state alone.
    typedef struct packed {
        logic robo_reset;
        logic busy;
        logic halted;
        logic stuck;
        logic motor_turn;
        logic claw;
    } status_t;

    function automatic status_t state_flags(robo_state_t s);
        status_t f;
        f = '0;
        case (s)
            S_IDLE:     f.robo_reset = 1'b1;
            S_RST_ROBO: begin
                f.robo_reset = 1'b1;
                f.busy       = 1'b1;
            end
            S_RUN:      f.busy = 1'b1;
            S_TURN: begin
                f.busy       = 1'b1;
                f.motor_turn = 1'b1;
            end
            S_COLLECT: begin
                f.busy = 1'b1;
                f.claw = 1'b1;
            end
            S_HALT:     f.halted = 1'b1;
            S_FAULT:    f.stuck  = 1'b1;
            default:    f.robo_reset = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/robo_timer.sv
// Loadable down-counter used to time the RST_ROBO, TURN and COLLECT phases.
// done is high during the last cycle of a loaded interval (count == 1), so
// a phase loaded with N lasts exactly N cycles when the owner leaves on done.
module robo_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         done
);

    // Load wins over counting; an enabled counter stops at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/robo_supervisor.sv
// Supervisor between a robot command FSM and its actuators. It holds the
// robot in reset on (re)start, turns commands into timed actuator pulses,
// counts completed debris collections, and stops the robot when it idles
// too long (HALT) or keeps turning without advancing (FAULT).
//
// Handshake: there is none; avancar/girar/recolher_entulho are level
// commands sampled on each rising edge while in RUN and ignored elsewhere,
// and start is a one-cycle pulse honoured only in IDLE, HALT and FAULT.
module robo_supervisor
    import robo_pkg::*;
#(
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int CLAW_CYCLES = DEF_CLAW_CYCLES,
    parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
    parameter int HALT_CYCLES = DEF_HALT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        avancar,
    input  logic        girar,
    input  logic        recolher_entulho,
    output logic        robo_reset,
    output logic        motor_fwd,
    output logic        motor_turn,
    output logic        claw,
    output logic        busy,
    output logic        halted,
    output logic        stuck,
    output logic [7:0]  entulho_count,
    output robo_state_t state_dbg
);

    localparam logic [CNT_W-1:0]   STUCK_LIM = CNT_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0]   HALT_LIM  = CNT_W'(HALT_CYCLES);
    localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES);
    localparam logic [TIMER_W-1:0] CLAW_LOAD = TIMER_W'(CLAW_CYCLES);
    localparam logic [TIMER_W-1:0] RST_LOAD  = TIMER_W'(RST_ROBO_CYCLES);

    robo_state_t        state;
    status_t            flags;
    logic [CNT_W-1:0]   turn_streak;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   streak_inc;
    logic [CNT_W-1:0]   idle_inc;

    logic               cmd_collect;
    logic               cmd_girar;
    logic               cmd_fault;
    logic               cmd_turn;
    logic               cmd_fwd;
    logic               restart;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_en;
    logic [TIMER_W-1:0] timer_count;
    logic               timer_done;

    robo_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_en),
        .count      (timer_count),
        .done       (timer_done)
    );

    // Command decode with collect > turn > forward priority, plus the
    // timer load request for whichever timed phase is about to begin.
    always_comb begin
        streak_inc  = turn_streak + CNT_W'(1);
        idle_inc    = idle_cnt + CNT_W'(1);
        cmd_collect = recolher_entulho;
        cmd_girar   = girar && !recolher_entulho;
        cmd_fault   = cmd_girar && (streak_inc == STUCK_LIM);
        cmd_turn    = cmd_girar && !cmd_fault;
        cmd_fwd     = avancar && !girar && !recolher_entulho;
        restart     = start && ((state == S_IDLE) || (state == S_HALT) ||
                                (state == S_FAULT));

        timer_load  = 1'b0;
        timer_value = '0;
        if (restart) begin
            timer_load  = 1'b1;
            timer_value = RST_LOAD;
        end else if ((state == S_RUN) && cmd_collect) begin
            timer_load  = 1'b1;
            timer_value = CLAW_LOAD;
        end else if ((state == S_RUN) && cmd_turn) begin
            timer_load  = 1'b1;
            timer_value = TURN_LOAD;
        end

        timer_en = (state == S_RST_ROBO) || (state == S_TURN) ||
                   (state == S_COLLECT);
    end

    // Supervisor FSM; every output is registered alongside the state it
    // belongs to, so outputs change on the same edge as the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            flags         <= state_flags(S_IDLE);
            motor_fwd     <= 1'b0;
            entulho_count <= '0;
            turn_streak   <= '0;
            idle_cnt      <= '0;
        end else begin
            motor_fwd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (restart) begin
                        state <= S_RST_ROBO;
                        flags <= state_flags(S_RST_ROBO);
                    end
                end

                S_RST_ROBO: begin
                    if (timer_done) begin
                        state <= S_RUN;
                        flags <= state_flags(S_RUN);
                    end
                end

                S_RUN: begin
                    if (cmd_collect) begin
                        idle_cnt <= '0;
                        state    <= S_COLLECT;
                        flags    <= state_flags(S_COLLECT);
                    end else if (cmd_girar) begin
                        idle_cnt    <= '0;
                        turn_streak <= streak_inc;
                        if (cmd_fault) begin
                            state <= S_FAULT;
                            flags <= state_flags(S_FAULT);
                        end else begin
                            state <= S_TURN;
                            flags <= state_flags(S_TURN);
                        end
                    end else if (cmd_fwd) begin
                        idle_cnt    <= '0;
                        turn_streak <= '0;
                        motor_fwd   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_inc;
                        if (idle_inc == HALT_LIM) begin
                            state <= S_HALT;
                            flags <= state_flags(S_HALT);
                        end
                    end
                end

                S_TURN: begin
                    if (timer_done) begin
                        state <= S_RUN;
                        flags <= state_flags(S_RUN);
                    end
                end

                S_COLLECT: begin
                    if (timer_done) begin
                        if (entulho_count != 8'hFF) begin
                            entulho_count <= entulho_count + 8'd1;
                        end
                        state <= S_RUN;
                        flags <= state_flags(S_RUN);
                    end
                end

                S_HALT, S_FAULT: begin
                    if (restart) begin
                        turn_streak <= '0;
                        idle_cnt    <= '0;
                        state       <= S_RST_ROBO;
                        flags       <= state_flags(S_RST_ROBO);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    flags <= state_flags(S_IDLE);
                end
            endcase
        end
    end

    assign {robo_reset, busy, halted, stuck, motor_turn, claw} = flags;
    assign state_dbg = state;

endmodule

// File: tb/tb_robo_supervisor.sv
// Bench for robo_supervisor: directed scenarios plus random command streams,
// all checked against a counter-based behavioural model of the supervisor.
module tb_robo_supervisor;

  localparam int TURN_CYCLES = 8;
  localparam int CLAW_CYCLES = 4;
  localparam int STUCK_LIMIT = 4;
  localparam int HALT_CYCLES = 4;
  localparam int RST_CYCLES  = 2;

  logic       clock;
  logic       reset;
  logic       start;
  logic       avancar;
  logic       girar;
  logic       recolher_entulho;
  logic       robo_reset;
  logic       motor_fwd;
  logic       motor_turn;
  logic       claw;
  logic       busy;
  logic       halted;
  logic       stuck;
  logic [7:0] entulho_count;
  logic [2:0] state_dbg;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  // Behavioural model: remaining-cycle counters for each timed phase.
  bit m_started;
  bit m_active;
  bit m_halted;
  bit m_stuck;
  bit m_fwd;
  int m_rst_left;
  int m_turn_left;
  int m_claw_left;
  int m_streak;
  int m_idle;
  int m_count;

  logic [14:0] dut_vec;
  assign dut_vec = {robo_reset, busy, halted, stuck, motor_fwd, motor_turn,
                    claw, entulho_count};

  robo_supervisor #(
    .TURN_CYCLES(TURN_CYCLES),
    .CLAW_CYCLES(CLAW_CYCLES),
    .STUCK_LIMIT(STUCK_LIMIT),
    .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avancar          (avancar),
    .girar            (girar),
    .recolher_entulho (recolher_entulho),
    .robo_reset       (robo_reset),
    .motor_fwd        (motor_fwd),
    .motor_turn       (motor_turn),
    .claw             (claw),
    .busy             (busy),
    .halted           (halted),
    .stuck            (stuck),
    .entulho_count    (entulho_count),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_started   = 0;
    m_active    = 0;
    m_halted    = 0;
    m_stuck     = 0;
    m_fwd       = 0;
    m_rst_left  = 0;
    m_turn_left = 0;
    m_claw_left = 0;
    m_streak    = 0;
    m_idle      = 0;
    m_count     = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic s, input logic a, input logic g,
                            input logic r);
    m_fwd = 0;
    if (!m_active) begin
      if (s) begin
        m_started  = 1;
        m_active   = 1;
        m_halted   = 0;
        m_stuck    = 0;
        m_streak   = 0;
        m_idle     = 0;
        m_rst_left = RST_CYCLES;
      end
    end else if (m_rst_left > 0) begin
      m_rst_left--;
    end else if (m_turn_left > 0) begin
      m_turn_left--;
    end else if (m_claw_left > 0) begin
      m_claw_left--;
      if (m_claw_left == 0) begin
        if (m_count < 255) m_count++;
        exp_q.push_back(8'(m_count));
      end
    end else if (r) begin
      m_idle      = 0;
      m_claw_left = CLAW_CYCLES;
    end else if (g) begin
      m_idle = 0;
      m_streak++;
      if (m_streak == STUCK_LIMIT) begin
        m_active = 0;
        m_stuck  = 1;
      end else begin
        m_turn_left = TURN_CYCLES;
      end
    end else if (a) begin
      m_idle   = 0;
      m_streak = 0;
      m_fwd    = 1;
    end else begin
      m_idle++;
      if (m_idle == HALT_CYCLES) begin
        m_active = 0;
        m_halted = 1;
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    return {(!m_started || (m_rst_left > 0)), m_active, m_halted, m_stuck,
            m_fwd, (m_turn_left > 0), (m_claw_left > 0), 8'(m_count)};
  endfunction

  // robo_reset is left unconstrained while faulted.
  function automatic logic [14:0] cmp_mask();
    return m_stuck ? 15'h3FFF : 15'h7FFF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic a, input logic g,
                      input logic r);
    start            = s;
    avancar          = a;
    girar            = g;
    recolher_entulho = r;
    @(posedge clock);
    model_edge(s, a, g, r);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    avancar = 1'b0;
    girar = 1'b0;
    recolher_entulho = 1'b0;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    model_reset();
    checks++;
    if (dut_vec !== 15'h4000) begin
      failures++;
      $display("FAIL reset_values: got %h want %h", dut_vec, 15'h4000);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rbit(), rbit(), rbit());
      checks++;
      if (busy !== 1'b0 || robo_reset !== 1'b1) begin
        failures++;
        $display("FAIL no_auto_start %0d: busy=%b robo_reset=%b want 0/1", i, busy, robo_reset);
      end
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL idle_model %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_start();
    logic [2:0] want_rr;
    want_rr = 3'b110;
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (robo_reset !== want_rr[2-i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL start_seq %0d: robo_reset=%b busy=%b want %b/1", i, robo_reset, busy, want_rr[2-i]);
      end
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL start_model %0d: got %h want %h state=%0d", i, dut_vec, exp_vec(), state_dbg);
      end
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i < 3, 1'b0, 1'b0);
      checks++;
      if (motor_fwd !== logic'(i < 3)) begin
        failures++;
        $display("FAIL forward %0d: motor_fwd=%b want %b", i, motor_fwd, i < 3);
      end
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL forward_model %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_turn();
    int seen;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) step(1'b0, 1'b0, 1'b1, 1'b0);
      else step(rbit(), rbit(), rbit(), rbit());
      if (motor_turn === 1'b1) seen++;
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL turn_model %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (seen != TURN_CYCLES || busy !== 1'b1 || motor_turn !== 1'b0) begin
      failures++;
      $display("FAIL turn_length: cycles=%0d busy=%b want %0d/1", seen, busy, TURN_CYCLES);
    end
  endtask

  task automatic test_collect_priority();
    int seen;
    bit turned;
    seen = 0;
    turned = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b0, 1'b0, 1'b1, 1'b1);
      else step(rbit(), rbit(), rbit(), rbit());
      if (claw === 1'b1) seen++;
      if (motor_turn !== 1'b0) turned = 1;
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL collect_model %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (seen != CLAW_CYCLES || turned || entulho_count !== 8'd1) begin
      failures++;
      $display("FAIL collect_priority: claw_cycles=%0d turned=%0d count=%0d want %0d/0/1", seen, turned, entulho_count, CLAW_CYCLES);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (entulho_count !== e) begin
        failures++;
        $display("FAIL collect_sb: count=%0d want %0d", entulho_count, e);
      end
    end
  endtask

  task automatic test_stuck();
    logic [7:0] saved;
    saved = entulho_count;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < STUCK_LIMIT - 1; t++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < TURN_CYCLES; i++) begin
        step(1'b0, rbit(), rbit(), rbit());
        checks++;
        if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
          failures++;
          $display("FAIL stuck_turns %0d.%0d: got %h want %h", t, i, dut_vec, exp_vec());
        end
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (stuck !== 1'b1 || busy !== 1'b0 || motor_turn !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL stuck_entry: stuck=%b busy=%b turn=%b halted=%b want 1/0/0/0", stuck, busy, motor_turn, halted);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, rbit(), rbit(), rbit());
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL stuck_hold %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    step(1'b1, rbit(), rbit(), rbit());
    checks++;
    if (stuck !== 1'b0 || robo_reset !== 1'b1 || busy !== 1'b1 || entulho_count !== saved) begin
      failures++;
      $display("FAIL stuck_restart: stuck=%b rr=%b busy=%b count=%0d want 0/1/1/%0d", stuck, robo_reset, busy, entulho_count, saved);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL stuck_rerun %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < HALT_CYCLES; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (halted !== logic'(i == HALT_CYCLES - 1)) begin
        failures++;
        $display("FAIL halt_idle %0d: halted=%b want %b", i, halted, i == HALT_CYCLES - 1);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (dut_vec !== {7'b0010000, 8'(m_count)}) begin
      failures++;
      $display("FAIL halt_hold: got %h want %h", dut_vec, {7'b0010000, 8'(m_count)});
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (halted !== 1'b0 || busy !== 1'b1 || robo_reset !== 1'b1) begin
      failures++;
      $display("FAIL halt_restart: halted=%b busy=%b rr=%b want 0/1/1", halted, busy, robo_reset);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL halt_rerun %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_turn();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, rbit(), rbit(), rbit());
    checks++;
    if (motor_turn !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_turn: motor_turn=%b want 1", motor_turn);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (motor_turn !== 1'b0 || robo_reset !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: turn=%b rr=%b busy=%b want 0/1/0", motor_turn, robo_reset, busy);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
      failures++;
      $display("FAIL post_reset_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) == 0, rbit(), $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0);
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL random %0d: got %h want %h state=%0d", i, dut_vec, exp_vec(), state_dbg);
      end
      checks++;
      if (32'(motor_fwd) + 32'(motor_turn) + 32'(claw) > 1) begin
        failures++;
        $display("FAIL actuator_onehot %0d: fwd=%b turn=%b claw=%b want at most one", i, motor_fwd, motor_turn, claw);
      end
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (entulho_count !== e) begin
          failures++;
          $display("FAIL random_sb %0d: count=%0d want %0d", i, entulho_count, e);
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1300; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ((dut_vec & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        failures++;
        $display("FAIL saturate_model %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (entulho_count !== e) begin
          failures++;
          $display("FAIL saturate_sb %0d: count=%0d want %0d", i, entulho_count, e);
        end
      end
    end
    checks++;
    if (entulho_count !== 8'd255) begin
      failures++;
      $display("FAIL saturate_final: count=%0d want 255", entulho_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    avancar = 1'b0;
    girar = 1'b0;
    recolher_entulho = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_forward();
    test_turn();
    test_collect_priority();
    test_stuck();
    test_halt();
    test_reset_mid_turn();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
